// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan display driver.
package seg_scan_pkg;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment patterns {g,f,e,d,c,b,a} indexed by BCD value; 10..15 blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        {6{SEG_BLANK}},
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_if.sv
// Digit-value load port and display-bank outputs of seg_scan.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] Bcd;
    logic [DIGITS-1:0]   Dp;
    logic                Load;
    logic [7:0]          Seg;
    logic [DIGITS-1:0]   Dig;
    logic                Frame;

    modport master (output Bcd, Dp, Load, input Seg, Dig, Frame);
    modport slave  (input Bcd, Dp, Load, output Seg, Dig, Frame);
endinterface

// File: rtl/seg_scan_bcd_to_seg7.sv
// Combinational BCD to 7-segment decode (a..g), values above 9 blank.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner with frame-synchronous buffer promotion.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_SHOW | digit idx enabled, prescaler counting
//   ST_GAP  | all digits off, gap counter counting
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIV_MAX = 49999,
    parameter int GAP_CYC = 2
) (
    input  logic     CP,
    input  logic     MRN,
    seg_scan_if.slave bus
);

    localparam int IW = $clog2(DIGITS);
    localparam int PW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_MAX);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                boundary;

    logic [4*DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0] act_bcd_q, act_bcd_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;

    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_q, frame_d;

    logic [3:0]          cur_bcd;
    logic                cur_dp;
    logic [6:0]          cur_seg;
    logic                blank;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        gap_d    = gap_q;
        boundary = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (presc_q == PRESC_LAST) begin
                    state_d = ST_GAP;
                    presc_d = '0;
                    gap_d   = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_SHOW;
                    gap_d   = '0;
                    presc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    // Frame is registered from next-state so it is high during the boundary cycle itself.
    assign frame_d = (state_d == ST_GAP) && (gap_d == GAP_LAST) && (idx_d == IDX_LAST);

    always_comb begin
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        act_bcd_d  = act_bcd_q;
        act_dp_d   = act_dp_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (bus.Load) begin
                act_bcd_d = bus.Bcd;
                act_dp_d  = bus.Dp;
            end else if (pend_vld_q) begin
                act_bcd_d = pend_bcd_q;
                act_dp_d  = pend_dp_q;
            end
        end else if (bus.Load) begin
            pend_bcd_d = bus.Bcd;
            pend_dp_d  = bus.Dp;
            pend_vld_d = 1'b1;
        end
    end

    assign cur_bcd = act_bcd_q[4*idx_q +: 4];
    assign cur_dp  = act_dp_q[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_above;

    // lz[i]: digit i and every more significant digit are zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_bcd_q[4*i +: 4] == 4'd0);
            lz[i]      = zero_above;
        end
        lz[0] = 1'b0;
    end

    assign blank = lz[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d = 8'h00;
        dig_d = '1;
        if (state_q == ST_SHOW) begin
            seg_d        = {cur_dp, (blank ? SEG_BLANK : cur_seg)};
            dig_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state_q    <= ST_SHOW;
            idx_q      <= '0;
            presc_q    <= '0;
            gap_q      <= '0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            act_bcd_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= 8'h00;
            dig_q      <= '1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            gap_q      <= gap_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            act_bcd_q  <= act_bcd_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.Seg   = seg_q;
    assign bus.Dig   = dig_q;
    assign bus.Frame = frame_q;

endmodule
